// File: rtl/ntt_ctrl.sv
// Address/strobe sequencer for one Kyber butterfly: seven layers of 128 butterflies,
// with a drain between layers so the next layer never reads an unwritten coefficient.
module ntt_ctrl #(
  parameter int BF_LAT  = 7,
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       bf_en,
  output logic       bf_mode,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_addr,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam int D  = BF_LAT + RAM_LAT;
  localparam int DW = $clog2(D + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_layer;
  logic [6:0]      r_bfly;
  logic [DW-1:0]   r_dcnt;
  logic            r_mode;
  logic            r_busy;
  logic            r_done;
  logic            r_bf_en;
  logic            r_rd_en;
  logic [22:0]     r_addr;
  logic [16:0]     r_dly [D];

  // Packs {addr_a, addr_b, tw} for butterfly bf of layer l.
  function automatic logic [22:0] f_addr(input logic m, input logic [2:0] l,
                                         input logic [6:0] bf);
    logic [3:0] s;
    logic [8:0] g, msk, a, b, tw;
    s   = m ? ({1'b0, l} + 4'd1) : (4'd7 - {1'b0, l});
    g   = {2'b00, bf} >> s;
    msk = (9'd1 << s) - 9'd1;
    a   = (g << (s + 4'd1)) | ({2'b00, bf} & msk);
    b   = a + (9'd1 << s);
    tw  = m ? ((9'd128 >> l) - 9'd1 - g) : ((9'd1 << l) + g);
    return {a[7:0], b[7:0], tw[6:0]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_layer <= '0;
      r_bfly  <= '0;
      r_dcnt  <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bf_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_layer <= '0;
            r_bfly  <= '0;
            r_mode  <= mode;
            r_busy  <= 1'b1;
            r_bf_en <= 1'b1;
            r_rd_en <= 1'b1;
            r_addr  <= f_addr(mode, 3'd0, 7'd0);
          end
        end
        S_RUN: begin
          if (r_bfly == 7'd127) begin
            r_state <= S_DRAIN;
            r_dcnt  <= '0;
            r_rd_en <= 1'b0;
            r_addr  <= '0;
          end else begin
            r_bfly <= r_bfly + 7'd1;
            r_addr <= f_addr(r_mode, r_layer, r_bfly + 7'd1);
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DW'(D - 1)) begin
            if (r_layer == 3'd6) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_bf_en <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_layer <= r_layer + 3'd1;
              r_bfly  <= '0;
              r_rd_en <= 1'b1;
              r_addr  <= f_addr(r_mode, r_layer + 3'd1, 7'd0);
            end
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write-back delay line: {valid, addr_a, addr_b}, D stages, never flushed except by reset.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_dly
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dly[gi] <= '0;
        end else if (gi == 0) begin
          r_dly[gi] <= {r_rd_en, r_addr[22:7]};
        end else begin
          r_dly[gi] <= r_dly[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign busy      = r_busy;
  assign done      = r_done;
  assign bf_en     = r_bf_en;
  assign bf_mode   = r_mode;
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_addr[22:15];
  assign rd_addr_b = r_addr[14:7];
  assign tw_addr   = r_addr[6:0];
  assign wr_en     = r_dly[D-1][16];
  assign wr_addr_a = r_dly[D-1][15:8];
  assign wr_addr_b = r_dly[D-1][7:0];

endmodule
